spad_quench_arbiter: RTL
========================

Name: spad_quench_arbiter

Overview:
- Synchronous controller for N_CH SPAD front-end channels.
- Synchronizes each channel's asynchronous trig, shares one TDC capture slot between channels through round-robin arbitration, then quenches each serviced channel by driving its rst_auto for a programmed dead time.
- rst_auto is driven only while that channel's time_gate is low.
- Sits between the SPAD array and the shared TDC core, and maintains event and drop statistics.

Parameters:
N_CH, 4, number of SPAD channels (2..16)
HOLD_CYC, 8, cycles a serviced trig is held after TDC ack before quench (1..255)
DEAD_CYC, 12, cycles rst_auto stays asserted per quench (1..255)
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; low blocks new captures and aborts pending ones
trig  input  N_CH  per-channel SPAD trigger, asynchronous to clk
time_gate  input  N_CH  per-channel SPAD gate, asynchronous to clk
rst_auto  output  N_CH  per-channel quench/reset to the SPAD, registered
tdc_req  output  1  capture request to the shared TDC
tdc_ch  output  clog2(N_CH)  channel index of the current request
tdc_ack  input  1  TDC accepted the request
cnt_clr  input  1  synchronous clear of both counters
evt_cnt  output  CNT_W  serviced events, saturating
drop_cnt  output  CNT_W  aborted events, saturating
busy  output  1  high while any channel is not IDLE

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - all outputs to 0;
  - all channel FSMs to IDLE;
  - the round-robin pointer to N_CH-1, so ch0 wins the first grant;
  - the synchronizer flops to 0.
- Synchronization: trig and time_gate each pass through a 2-flop synchronizer. A trig rise is detected on the synchronized value (sync2 & ~sync3).
  - Asynchronous trig rise to PEND is 3 clk edges.
- Per-channel FSM:
  - IDLE: if en and a trig rise is detected -> PEND. A rise while en=0 is ignored and not counted.
  - PEND: the channel requests the arbiter. If en=0 -> QWAIT and drop_cnt+1. When granted and tdc_ack=1 -> HOLD.
  - HOLD: the counter loads HOLD_CYC-1 on entry and counts down. At 0 -> QWAIT.
  - QWAIT: wait for synchronized time_gate=0, then -> QUENCH. The channel stays here indefinitely while the gate is high.
  - QUENCH: rst_auto[i]=1. The counter loads DEAD_CYC-1 and counts down. At 0 -> IDLE, and rst_auto[i] drops on the same edge.
  - rst_auto[i] is high only in QUENCH. Minimum width is exactly DEAD_CYC cycles.
  - Any trig edge while not IDLE is ignored, because the SPAD holds trig high until quenched.
- Arbiter / TDC handshake:
  - When idle (tdc_req=0), pick the first PEND channel searching upward from pointer+1, wrapping modulo N_CH.
  - Next cycle: tdc_req=1 and tdc_ch=index. Both stay stable until tdc_ack.
  - On the cycle tdc_ack=1 with tdc_req=1:
    - the pointer is set to tdc_ch;
    - tdc_req drops on the next edge;
    - evt_cnt increments.
  - The next grant can be issued the cycle after the drop, giving at most one request per 2 cycles.
  - tdc_ack while tdc_req=0 is ignored.
  - If en falls while the granted channel is still unacked:
    - tdc_req drops next edge;
    - that channel goes to QWAIT and counts as a drop;
    - no evt_cnt change.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr has priority over increments in the same cycle.
  - If an increment and a drop occur in the same cycle, each counter updates independently.
- Simultaneous detection: several channels entering PEND on the same edge are served in round-robin order, with no loss.
- busy = OR over channels of (state != IDLE).

Test Plan:
- Single hit: after reset, pulse trig[0]; ack 1 cycle after tdc_req -> tdc_req rises 4 edges after trig with tdc_ch=0. HOLD lasts 8 cycles, then rst_auto[0] is high for exactly 12 cycles; evt_cnt=1 and drop_cnt=0.
- Fairness: raise trig[3:0]=4'b1111 together and ack every request -> grant order 0,1,2,3. A second burst then yields order 0,1,2,3 again (pointer=3). evt_cnt=8.
- Gate interlock: hold time_gate[1]=1 for 40 cycles spanning HOLD end -> rst_auto[1] stays 0 until 2 cycles after time_gate falls, then is high 12 cycles.
- Abort: trig[2] rises, tdc_ack held 0, en dropped after 2 cycles of tdc_req -> tdc_req falls, ch2 quenches, drop_cnt=1, evt_cnt=0. A trig rise while en=0 leaves the FSM IDLE.
- Saturation/clear: with CNT_W=3, serve 9 events -> evt_cnt=7. Assert cnt_clr coincident with an ack -> evt_cnt=0.
- Async reset mid-QUENCH: pull rst_n low during a QUENCH -> rst_auto, tdc_req and busy go 0 immediately, without waiting for a clk edge. After release, the next trig is served normally starting from ch0 priority.

Source files
------------

// File: rtl/spad_quench_arbiter.sv
// SPAD front-end controller: synchronizes per-channel triggers, shares one TDC
// capture slot round-robin, then quenches each serviced channel for a dead time.
module spad_quench_arbiter #(
    parameter int N_CH     = 4,
    parameter int HOLD_CYC = 8,
    parameter int DEAD_CYC = 12,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N_CH-1:0]         trig,
    input  logic [N_CH-1:0]         time_gate,
    output logic [N_CH-1:0]         rst_auto,
    output logic                    tdc_req,
    output logic [$clog2(N_CH)-1:0] tdc_ch,
    input  logic                    tdc_ack,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        evt_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    busy
);

    localparam int CH_W = $clog2(N_CH);
    localparam int PC_W = $clog2(N_CH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC - 1);
    localparam logic [7:0] DEAD_LD = 8'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PEND   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_QWAIT  = 3'd3,
        ST_QUENCH = 3'd4
    } ch_state_t;

    logic [N_CH-1:0]  trig_s1_r, trig_s2_r, trig_s3_r;
    logic [N_CH-1:0]  gate_s1_r, gate_s2_r;
    ch_state_t        state_r [N_CH];
    logic [7:0]       tmr_r [N_CH];
    logic [N_CH-1:0]  rise_s, pend_s, drop_s, act_s;
    logic [PC_W-1:0]  drop_num_s;
    logic [SUM_W-1:0] drop_sum_s;
    logic [CNT_W-1:0] drop_sat_s;
    logic [CH_W-1:0]  ptr_r, pick_idx_s;
    logic             pick_vld_s, ack_evt_s;

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
        return CH_W'((int'(base) + k) % N_CH);
    endfunction

    // Two-flop synchronizers plus an extra trig stage for rise detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_r <= '0;
            trig_s2_r <= '0;
            trig_s3_r <= '0;
            gate_s1_r <= '0;
            gate_s2_r <= '0;
        end else begin
            trig_s1_r <= trig;
            trig_s2_r <= trig_s1_r;
            trig_s3_r <= trig_s2_r;
            gate_s1_r <= time_gate;
            gate_s2_r <= gate_s1_r;
        end
    end

    // Per-channel status decode and saturating drop accumulation
    always_comb begin
        rise_s     = trig_s2_r & ~trig_s3_r;
        ack_evt_s  = tdc_req & tdc_ack & en;
        drop_num_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            pend_s[i] = (state_r[i] == ST_PEND);
            act_s[i]  = (state_r[i] != ST_IDLE);
        end
        drop_s = pend_s & {N_CH{~en}};
        for (int i = 0; i < N_CH; i++) begin
            drop_num_s = drop_num_s + PC_W'(drop_s[i]);
        end
        drop_sum_s = SUM_W'(drop_cnt) + SUM_W'(drop_num_s);
        if (drop_sum_s > SUM_W'(CNT_MAX)) begin
            drop_sat_s = CNT_MAX;
        end else begin
            drop_sat_s = drop_sum_s[CNT_W-1:0];
        end
    end

    // Round-robin search: highest k first so the nearest pending channel wins
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = ptr_r;
        for (int k = N_CH; k >= 1; k--) begin
            if (pend_s[rr_idx(ptr_r, k)]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = rr_idx(ptr_r, k);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    assign busy = |act_s;

    // TDC request handshake and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdc_req <= 1'b0;
            tdc_ch  <= '0;
            ptr_r   <= CH_W'(N_CH - 1);
        end else if (tdc_req) begin
            if (!en) begin
                tdc_req <= 1'b0;
            end else if (tdc_ack) begin
                tdc_req <= 1'b0;
                ptr_r   <= tdc_ch;
            end
        end else if (en && pick_vld_s) begin
            tdc_req <= 1'b1;
            tdc_ch  <= pick_idx_s;
        end
    end

    // Channel FSMs; rst_auto is set and cleared on the QUENCH entry/exit edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i]  <= ST_IDLE;
                tmr_r[i]    <= 8'd0;
                rst_auto[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (en && rise_s[i]) state_r[i] <= ST_PEND;
                    end
                    ST_PEND: begin
                        if (!en) begin
                            state_r[i] <= ST_QWAIT;
                        end else if (ack_evt_s && (tdc_ch == CH_W'(i))) begin
                            state_r[i] <= ST_HOLD;
                            tmr_r[i]   <= HOLD_LD;
                        end
                    end
                    ST_HOLD: begin
                        if (tmr_r[i] == 8'd0) state_r[i] <= ST_QWAIT;
                        else                  tmr_r[i]   <= tmr_r[i] - 8'd1;
                    end
                    ST_QWAIT: begin
                        if (!gate_s2_r[i]) begin
                            state_r[i]  <= ST_QUENCH;
                            tmr_r[i]    <= DEAD_LD;
                            rst_auto[i] <= 1'b1;
                        end
                    end
                    ST_QUENCH: begin
                        if (tmr_r[i] == 8'd0) begin
                            state_r[i]  <= ST_IDLE;
                            rst_auto[i] <= 1'b0;
                        end else begin
                            tmr_r[i] <= tmr_r[i] - 8'd1;
                        end
                    end
                    default: begin
                        state_r[i]  <= ST_IDLE;
                        rst_auto[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating statistics; clear wins over any same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (cnt_clr) begin
            evt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (ack_evt_s && (evt_cnt != CNT_MAX)) evt_cnt <= evt_cnt + CNT_W'(1);
            drop_cnt <= drop_sat_s;
        end
    end

endmodule
